iterative_shifter: RTL and testbench

//  Parametrised multi-cycle shifter for the EX stage. It generalises the fixed shift-left-by-2 to SLL/SRL/SRA with a variable amount.

---
 rtl/iterative_shifter_pkg.sv | 16 +
 rtl/iterative_shifter_shift_step.sv | 46 ++++
 rtl/iterative_shifter.sv | 116 +++++++++++
 tb/tb_iterative_shifter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/iterative_shifter_pkg.sv
// Shared op codes and FSM encoding for the iterative shifter.
// Optional rotate support is enabled with ITER_SHIFTER_ROTATE_EN.
package iterative_shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// One combinational shift step of up to STEP bits.
// Rotate-right is built only when ITER_SHIFTER_ROTATE_EN is defined.
module iterative_shifter_shift_step
    import iterative_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    localparam int unsigned KW   = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic [1:0]       op_i,
    input  logic [KW-1:0]    k_i,
    input  logic             fill_msb_i,
    output logic [WIDTH-1:0] shifted_o
);

    logic [WIDTH-1:0] srl;
    logic [WIDTH-1:0] hi_mask;

    assign srl     = work_i >> k_i;
    assign hi_mask = ~({WIDTH{1'b1}} >> k_i);

`ifdef ITER_SHIFTER_ROTATE_EN
    localparam int unsigned RW = $clog2(WIDTH) + 1;
    logic [RW-1:0] lsh;
    // k=0 gives a left shift of WIDTH, which yields zero
    assign lsh = RW'(WIDTH) - RW'(k_i);
`endif

    always_comb begin
        shifted_o = work_i;
        unique case (op_i)
            OP_SLL: shifted_o = work_i << k_i;
            OP_SRL: shifted_o = srl;
            OP_SRA: shifted_o = srl | (fill_msb_i ? hi_mask : '0);
            default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
                shifted_o = srl | (work_i << lsh);
`else
                shifted_o = work_i;
`endif
            end
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter, up to STEP bits per clock.
// Define ITER_SHIFTER_ROTATE_EN to enable op 11 as rotate-right.
module iterative_shifter
    import iterative_shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STEP    = 1,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   result_o
);

    localparam int unsigned KW = $clog2(STEP) + 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic               fill_q, fill_d;

    logic [SHAMT_W:0]   rem_ext;
    logic [SHAMT_W:0]   k_full;
    logic [KW-1:0]      k;
    logic [SHAMT_W-1:0] shamt_eff;
    logic [WIDTH-1:0]   shifted;

    assign rem_ext = {1'b0, rem_q};
    assign k_full  = (rem_ext < (SHAMT_W+1)'(STEP)) ? rem_ext
                                                    : (SHAMT_W+1)'(STEP);
    assign k       = KW'(k_full);

`ifdef ITER_SHIFTER_ROTATE_EN
    assign shamt_eff = shamt_i;
`else
    // Without rotate, op 11 completes as a zero-length shift
    assign shamt_eff = (op_i == OP_ROR) ? '0 : shamt_i;
`endif

    iterative_shifter_shift_step #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_step (
        .work_i    (work_q),
        .op_i      (op_q),
        .k_i       (k),
        .fill_msb_i(fill_q),
        .shifted_o (shifted)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        rem_d    = rem_q;
        op_d     = op_q;
        fill_d   = fill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    work_d = data_i;
                    op_d   = op_i;
                    fill_d = data_i[WIDTH-1];
                    rem_d  = shamt_eff;
                    if (shamt_eff != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = data_i;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                rem_d  = SHAMT_W'(rem_ext - k_full);
                if (rem_d == '0) begin
                    state_d  = ST_DONE;
                    result_d = shifted;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            op_q     <= OP_SLL;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            fill_q   <= fill_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: STEP=1 and STEP=4 instances side by side.
// Honours ITER_SHIFTER_ROTATE_EN for the op 11 expectations.
module tb_iterative_shifter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] data_i = '0;
    logic [4:0]  shamt_i = '0;
    logic        ready1, valid1, ready4, valid4;
    logic [31:0] result1, result4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    iterative_shifter #(.WIDTH(32), .STEP(1)) dut1 (
        .clock(clock), .reset(reset), .start_i(start_i), .op_i(op_i),
        .data_i(data_i), .shamt_i(shamt_i), .ready_o(ready1),
        .valid_o(valid1), .result_o(result1)
    );

    iterative_shifter #(.WIDTH(32), .STEP(4)) dut4 (
        .clock(clock), .reset(reset), .start_i(start_i), .op_i(op_i),
        .data_i(data_i), .shamt_i(shamt_i), .ready_o(ready4),
        .valid_o(valid4), .result_o(result4)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                              input logic [31:0] x,
                                              input int s);
        case (op)
            2'b00: return x << s;
            2'b01: return x >> s;
            2'b10: return $signed(x) >>> s;
            default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
                if (s == 0) return x;
                return (x >> s) | (x << (32 - s));
`else
                return x;
`endif
            end
        endcase
    endfunction

    // Cycle index (1 = cycle right after the accept edge) where valid is expected
    function automatic int exp_index(input logic [1:0] op, input int s,
                                     input int step);
        int eff;
        eff = s;
`ifndef ITER_SHIFTER_ROTATE_EN
        if (op == 2'b11) eff = 0;
`endif
        return (eff + step - 1) / step + 1;
    endfunction

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] data, input logic [4:0] shamt,
                          input logic [31:0] exp, input int busy_at);
        int e1, e4, last, first1, first4, cnt1, cnt4;
        e1 = exp_index(op, int'(shamt), 1);
        e4 = exp_index(op, int'(shamt), 4);
        last = ((e1 > e4) ? e1 : e4) + 4;
        first1 = -1; first4 = -1; cnt1 = 0; cnt4 = 0;
        @(negedge clock);
        start_i = 1'b1; op_i = op; data_i = data; shamt_i = shamt;
        @(posedge clock);
        #1;
        start_i = 1'b0; data_i = $urandom; shamt_i = 5'($urandom);
        for (int i = 1; i <= last; i++) begin
            @(negedge clock);
            if (valid1) begin
                cnt1++;
                if (first1 < 0) begin
                    first1 = i;
                    check({name, " res1"}, result1, exp);
                end
            end
            if (valid4) begin
                cnt4++;
                if (first4 < 0) begin
                    first4 = i;
                    check({name, " res4"}, result4, exp);
                end
            end
            if (i == busy_at) begin
                start_i = 1'b1; op_i = 2'b00;
                data_i = $urandom; shamt_i = 5'd5;
            end else begin
                start_i = 1'b0;
            end
        end
        check({name, " lat1"}, first1, e1);
        check({name, " lat4"}, first4, e4);
        check({name, " pulses1"}, cnt1, 1);
        check({name, " pulses4"}, cnt4, 1);
        check({name, " hold1"}, result1, exp);
        check({name, " hold4"}, result4, exp);
        check({name, " ready1"}, {31'd0, ready1}, 1);
        check({name, " ready4"}, {31'd0, ready4}, 1);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int vcnt;
        logic [1:0]  rop;
        logic [31:0] rdata;
        logic [4:0]  rsh;

        vecs[0] = '{"sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{"sra4", 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F};
        vecs[2] = '{"srl0", 2'b01, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF};
`ifdef ITER_SHIFTER_ROTATE_EN
        vecs[3] = '{"op11", 2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000};
`else
        vecs[3] = '{"op11", 2'b11, 32'h0000_0001, 5'd1, 32'h0000_0001};
`endif
        vecs[4] = '{"sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[5] = '{"srl7", 2'b01, 32'hF000_0000, 5'd7, 32'h01E0_0000};
        vecs[6] = '{"sra_pos", 2'b10, 32'h7000_0000, 5'd9, 32'h0038_0000};

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst ready1", {31'd0, ready1}, 1);
        check("rst ready4", {31'd0, ready4}, 1);
        check("rst valid1", {31'd0, valid1}, 0);
        check("rst valid4", {31'd0, valid4}, 0);
        check("rst result1", result1, 0);
        check("rst result4", result4, 0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].data, vecs[i].shamt,
                   vecs[i].exp, -1);

        run_op("busy", 2'b01, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 1);

        // Abort a long SRL with reset before either instance finishes
        @(negedge clock);
        start_i = 1'b1; op_i = 2'b01; data_i = 32'h1234_5678; shamt_i = 5'd16;
        @(posedge clock);
        #1 start_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            check("abort pre v1", {31'd0, valid1}, 0);
            check("abort pre v4", {31'd0, valid4}, 0);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort ready1", {31'd0, ready1}, 1);
        check("abort ready4", {31'd0, ready4}, 1);
        check("abort result1", result1, 0);
        check("abort result4", result4, 0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (valid1 || valid4) vcnt++;
        end
        check("abort no valid", vcnt, 0);

        for (int n = 0; n < 500; n++) begin
            rop = 2'($urandom_range(0, 3));
            rdata = $urandom;
            rsh = 5'($urandom_range(0, 31));
            run_op("rand", rop, rdata, rsh,
                   ref_shift(rop, rdata, int'(rsh)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
